// File: rtl/row_scan_sequencer.sv
// row_scan_sequencer
//   Steps a 4-bit row address through rows 0..15 for a downstream
//   4-to-16 decoder. Each row is held for dwell+1 cycles with the decoder
//   enabled. At the end of row 15 the block either wraps to row 0 (cont=1)
//   or returns to idle (cont=0). In both cases it pulses frame_done.
//
//   Optional build macro SCAN_BLANK_EN adds one blank cycle between
//   consecutive rows, including the 15->0 wrap. During that cycle ena=0,
//   busy=1, and a already holds the next row address. When the macro is
//   undefined, rows are driven back-to-back with ena continuously high.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a frame (ignored while busy; stop wins if both high)
//   stop       in   abort the running frame, no frame_done
//   cont       in   1 = wrap after row 15, 0 = single frame
//   dwell      in   row hold count (row held dwell+1 cycles), latched at start
//   a          out  row address
//   ena        out  decoder enable
//   busy       out  high in every non-idle state
//   frame_done out  one-cycle pulse after the last cycle of row 15
//
// All outputs are registered.
module row_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         a,
  output logic               ena,
  output logic               busy,
  output logic               frame_done
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;
  // State entered after a row completes (the next row address is already loaded).
  localparam state_t ROW_STEP = BLANK;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
  localparam state_t ROW_STEP = DRIVE;
`endif

  state_t             state_q, state_d;
  logic [3:0]         a_q, a_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               fd_d;
  logic               ena_q, busy_q, fd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      // ena/busy are registered copies of what the next state implies.
      ena_q   <= (state_d == DRIVE);
      busy_q  <= (state_d != IDLE);
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    fd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        a_d   = '0;
        cnt_d = '0;
        if (start && !stop) begin
          state_d = DRIVE;
          dwell_d = dwell;
        end
      end

      DRIVE: begin
        if (stop) begin
          // An abort takes precedence over end-of-frame, so no frame_done is issued.
          state_d = IDLE;
          a_d     = '0;
          cnt_d   = '0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end else begin
          cnt_d = '0;
          if (a_q != 4'd15) begin
            a_d     = a_q + 4'd1;
            state_d = ROW_STEP;
          end else begin
            fd_d = 1'b1;
            a_d  = '0;
            if (cont) begin
              state_d = ROW_STEP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

`ifdef SCAN_BLANK_EN
      BLANK: begin
        cnt_d = '0;
        if (stop) begin
          state_d = IDLE;
          a_d     = '0;
        end else begin
          state_d = DRIVE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        a_d     = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign a          = a_q;
  assign ena        = ena_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Testbench for row_scan_sequencer.
// The reference model expands an accepted frame into a queue of expected
// per-cycle output tuples {a, ena, busy, frame_done} and pops one tuple per
// clock edge. A compare process checks every cycle, and directed sections
// pin the model with hand-computed literals.
module tb_row_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [7:0] dwell;
  logic [3:0] a;
  logic       ena, busy, frame_done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  row_scan_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .dwell      (dwell),
    .a          (a),
    .ena        (ena),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ---------------- reference model ----------------
  // Tuple layout: [6:3] a, [2] ena, [1] busy, [0] frame_done.
  logic [6:0] q[$];
  logic [6:0] cur = 7'd0;
  logic [7:0] dwell_lat = 8'd0;

  task automatic push_frame(input bit wrap);
    for (int r = 0; r < 16; r++) begin
`ifdef SCAN_BLANK_EN
      if (r > 0 || wrap) q.push_back({4'(r), 1'b0, 1'b1, 1'b0});
`endif
      for (int k = 0; k <= int'(dwell_lat); k++) q.push_back({4'(r), 1'b1, 1'b1, 1'b0});
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = 7'd0;
      dwell_lat = 8'd0;
    end else if (cur[1] && stop) begin
      q.delete();
      cur = 7'd0;
    end else if (!cur[1]) begin
      if (start && !stop) begin
        dwell_lat = dwell;
        push_frame(1'b0);
        cur = q.pop_front();
      end else begin
        cur = 7'd0;
      end
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else if (cont) begin
      push_frame(1'b1);
      cur = q.pop_front();
      cur[0] = 1'b1;
    end else begin
      cur = 7'b0000_001;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a",          int'(a),          int'(cur[6:3]));
      check("ena",        int'(ena),        int'(cur[2]));
      check("busy",       int'(busy),       int'(cur[1]));
      check("frame_done", int'(frame_done), int'(cur[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  int ena_cnt, fd_t, a_at;
  bit found;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = 8'd0;
    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    check("reset_a", int'(a), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ena", int'(ena), 0);

    // Single frame, dwell=2, start sampled at edge "cycle 0".
    dwell = 8'd2; start = 1'b1;
    ena_cnt = 0; fd_t = -1; a_at = -1;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (ena) ena_cnt++;
      if (frame_done && fd_t < 0) fd_t = t;
`ifdef SCAN_BLANK_EN
      if (t == 21) a_at = int'(a);
`else
      if (t == 16) a_at = int'(a);
`endif
    end
    check("d2_ena_cycles", ena_cnt, 48);
`ifdef SCAN_BLANK_EN
    check("d2_fd_cycle", fd_t, 64);
`else
    check("d2_fd_cycle", fd_t, 49);
`endif
    check("d2_row5", a_at, 5);
    check("d2_idle_after", int'(busy), 0);

    // Continuous scan with dwell=0, then abort while a=7.
    dwell = 8'd0; cont = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (40) tick();
    check("cont_busy", int'(busy), 1);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (a == 4'd7 && ena) found = 1'b1;
      else tick();
    end
    check("stop_found_row7", int'(found), 1);
    stop = 1'b1;
    tick(); stop = 1'b0;
    check("stop_a", int'(a), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_fd", int'(frame_done), 0);

    // Reset mid-frame with start held high.
    cont = 1'b0; dwell = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    rst = 1'b1; start = 1'b1;
    tick(); rst = 1'b0; start = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_ena", int'(ena), 0);
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    check("restart_a", int'(a), 0);
    check("restart_ena", int'(ena), 1);

    // Start and stop together in idle: stop wins.
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", int'(busy), 0);

    // dwell=3 latched; change dwell and re-pulse start mid-frame.
    dwell = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    dwell = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("relatch_a", int'(a), 1);
    repeat (70) tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      cont  = $urandom_range(0, 1) == 1;
      dwell = 8'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
